// File: rtl/mul_div_if.sv
// Handshake and result bundle between the control unit and the
// iterative multiply/divide unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, x, y,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier and restoring divider owning HI/LO.
// One step per clock; sign fix-up and HI/LO write in a final FIX cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   b, ph, pl;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_q, neg_r, dz;
  logic               is_div, done_q;
  logic               sgn, xs, ys;
  logic [WIDTH-1:0]   xa, ya;
  logic [WIDTH:0]     add, sh, dif;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign sgn = ~bus.op[0];
  assign xs  = sgn & bus.x[WIDTH-1];
  assign ys  = sgn & bus.y[WIDTH-1];
  assign xa  = xs ? -bus.x : bus.x;
  assign ya  = ys ? -bus.y : bus.y;

  // ph:pl is the product during MUL and remainder:quotient during DIV
  assign add  = {1'b0, ph} + (pl[0] ? {1'b0, b} : '0);
  assign sh   = {ph, pl[WIDTH-1]};
  assign dif  = sh - {1'b0, b};
  assign prod = neg_q ? -{ph, pl} : {ph, pl};
  assign quo  = neg_q ? -pl : pl;
  assign rem  = neg_r ? -ph : ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.start && bus.op[2:1] == 2'b00)
          state_d = MUL;
        else if (bus.start && bus.op[2:1] == 2'b01)
          state_d = DIV;
      end
      MUL, DIV: if (cnt == '0) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      b      <= '0;
      ph     <= '0;
      pl     <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      is_div <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          unique case (1'b1)
            (bus.op[2] == 1'b0): begin
              cnt    <= CW'(WIDTH - 1);
              b      <= ya;
              ph     <= '0;
              pl     <= xa;
              neg_q  <= xs ^ ys;
              neg_r  <= xs;
              dz     <= (bus.y == '0);
              is_div <= bus.op[1];
            end
            (bus.op == 3'd4): hi_q <= bus.x;
            (bus.op == 3'd5): lo_q <= bus.x;
            default: ;
          endcase
        end
        MUL: begin
          ph  <= add[WIDTH:1];
          pl  <= {add[0], pl[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
        end
        DIV: begin
          if (!dif[WIDTH]) begin
            ph <= dif[WIDTH-1:0];
            pl <= {pl[WIDTH-2:0], 1'b1};
          end else begin
            ph <= sh[WIDTH-1:0];
            pl <= {pl[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            // divide by zero: quotient all ones, remainder is x itself
            lo_q <= dz ? '1 : quo;
            hi_q <= rem;
          end else begin
            {hi_q, lo_q} <= prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks of mul_div_unit: results, latency, hazards, reset.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   cmp = 0;
  int   errs = 0;
  int   n;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.x     = a;
    bus.y     = b;
    tick();
    bus.start = 1'b0;
    n = 0;
  endtask

  task automatic wait_done();
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (2) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    #3 rst_n = 1'b1;
    tick();

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy_e1", 32'(bus.busy), 32'd1);
    chk("multu_hold_lo", bus.lo, 32'h0);
    wait_done();
    chk("multu_lat", 32'(n), 32'd33);
    chk("multu_busy_done", 32'(bus.busy), 32'd0);
    chk("multu_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_lo", bus.lo, 32'h00000001);
    tick();
    chk("done_pulse", 32'(bus.done), 32'd0);

    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_done();
    chk("mult_lat", 32'(n), 32'd33);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFEB);

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done();
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    issue(3'd3, 32'd100, 32'd7);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done();
    chk("divu_lat", 32'(n), 32'd33);
    chk("divu_hi", bus.hi, 32'd2);
    chk("divu_lo", bus.lo, 32'd14);

    issue(3'd3, 32'h12345678, 32'h0);
    wait_done();
    chk("dz_hi", bus.hi, 32'h12345678);
    chk("dz_lo", bus.lo, 32'hFFFFFFFF);

    issue(3'd2, 32'hFFFFFFF9, 32'h0);
    wait_done();
    chk("sdz_hi", bus.hi, 32'hFFFFFFF9);
    chk("sdz_lo", bus.lo, 32'hFFFFFFFF);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    chk("ovf_hi", bus.hi, 32'h0);
    chk("ovf_lo", bus.lo, 32'h80000000);

    issue(3'd4, 32'hAAAA5555, 32'h0);
    chk("mthi_hi", bus.hi, 32'hAAAA5555);
    chk("mthi_done", 32'(bus.done), 32'd0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    issue(3'd5, 32'h11112222, 32'h0);
    chk("mtlo_lo", bus.lo, 32'h11112222);
    issue(3'd6, 32'h99999999, 32'h1);
    chk("rsv_busy", 32'(bus.busy), 32'd0);
    chk("rsv_hi", bus.hi, 32'hAAAA5555);
    chk("rsv_lo", bus.lo, 32'h11112222);

    issue(3'd0, 32'd5, 32'hFFFFFFFA);
    repeat (9) begin
      tick();
      n++;
    end
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.x     = 32'hDEADBEEF;
    bus.y     = 32'h12345678;
    tick();
    n++;
    bus.start = 1'b0;
    chk("haz_lo", bus.lo, 32'h11112222);
    chk("haz_busy", 32'(bus.busy), 32'd1);
    wait_done();
    chk("haz_lat", 32'(n), 32'd33);
    chk("haz_hi", bus.hi, 32'hFFFFFFFF);
    chk("haz_res_lo", bus.lo, 32'hFFFFFFE2);

    issue(3'd0, 32'd1234, 32'd5678);
    repeat (14) tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("amid_busy", 32'(bus.busy), 32'd0);
    chk("amid_hi", bus.hi, 32'h0);
    chk("amid_lo", bus.lo, 32'h0);
    #10 rst_n = 1'b1;
    tick();
    issue(3'd3, 32'd9, 32'd3);
    wait_done();
    chk("post_lat", 32'(n), 32'd33);
    chk("post_hi", bus.hi, 32'd0);
    chk("post_lo", bus.lo, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
